ascon_aead_fsm_param: RTL
=========================

# ascon_aead_fsm_param

Parametrised control FSM for the next-generation Ascon-AEAD128 core, driving the same datapath controls as the current core FSM. Unlike the current core FSM, it generalises permutation round counts and rounds-per-cycle unrolling, and owns its round counter. It adds explicit last-block flags, encrypt/decrypt mode with tag-check result, and a synchronous abort. It sits between the core's host handshake and the permutation/xor datapath.

## Interface
- PA_ROUNDS, 12, rounds of initialisation/finalisation permutation (1..12)
- PB_ROUNDS, 8, rounds of data permutation (1..12)
- UNROLL, 1, permutation rounds per cycle; must divide PA_ROUNDS and PB_ROUNDS, else elaboration error
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  begin new AEAD operation (sampled in IDLE only)
- decrypt  in  1  mode, captured with start (0 encrypt, 1 decrypt)
- abort  in  1  synchronous abort, any state
- valid_ad / last_ad  in  1 / 1  AD block valid / final AD block
- valid_db_in / last_db  in  1 / 1  data block valid / final (possibly empty, datapath-padded) block
- tag_match  in  1  datapath comparator result, meaningful in TAG state
- rnd_idx  out  4  round-constant index of first round in current group
- perm_en  out  1  apply UNROLL rounds this cycle
- en_internal / en_new_aead  out  1 / 1  state register enable / capture key, nonce, mode
- sel_state  out  1  0 loop, 1 input state
- sel_din / sel_dout  out  1 / 1  0 AD, 1 DB / 0 data, 1 tag
- sel_xor_data  out  1  xor input into rate
- sel_xor_key  out  2  00 none, 01 0‖K, 10 K‖0, 11 K‖K
- sel_decrypt  out  1  replace rate with ciphertext (decrypt DB cycles)
- end_ad  out  1  domain-separation bit xor
- ready, valid_db_out, valid_tag, auth_fail, busy  out  1 each

## Operation
- States: IDLE, LOAD, INIT, WAIT_AD, ABS_AD, WAIT_DB, ABS_DB, FINAL, TAG.
- Round counter k counts groups 0..N/UNROLL−1; rnd_idx = 12−N+k·UNROLL, N = PA_ROUNDS in INIT/FINAL, PB_ROUNDS in ABS_*; perm_en=1 in INIT/ABS_*/FINAL; k cleared on every state entry.
- IDLE: start → LOAD (mode registered). LOAD: en_new_aead, en_internal, sel_state=1; → INIT.
- INIT: last group → WAIT_AD.
- WAIT_AD (ready=1): valid_ad has priority over valid_db_in. valid_ad → ABS_AD. valid_db_in → ABS_DB (or FINAL if last_db).
- ABS_AD: first cycle sel_din=0, sel_xor_data=1; sel_xor_key=01 if first absorption. Last group → WAIT_DB if last_ad, else WAIT_AD.
- WAIT_DB (ready=1): valid_db_in → ABS_DB, or FINAL if last_db. valid_ad ignored.
- ABS_DB: first cycle sel_din=1, sel_xor_data=1, valid_db_out=1, sel_decrypt=decrypt.
- ABS_DB, entry directly from WAIT_AD (empty AD): sel_xor_key=01 and end_ad=1 on that cycle. Last group → WAIT_DB.
- FINAL: first cycle xors the final DB block with valid_db_out=1, sel_decrypt=decrypt.
- FINAL, key xor: sel_xor_key=11 if nothing absorbed before, else 10.
- FINAL, end_ad=1 on the first cycle iff domain separation not yet applied. Last group → TAG.
- Domain separation is applied exactly once, either on entry to WAIT_DB after AD or on the first DB xor when AD is empty.
- TAG: sel_xor_key=01, sel_dout=1, valid_tag=1, auth_fail=decrypt & ~tag_match; → IDLE.
- abort: next state IDLE, k cleared, no valid_tag; abort beats start.
- busy=1 in every state except IDLE.

## Timing
- Reset: state IDLE, k=0, all flags cleared; all outputs 0 except rnd_idx = 12−PA_ROUNDS.
- All outputs are decoded combinationally from registered state, k and flags.
- Transfer occurs when valid & ready in a WAIT state.
- start→first ready: 1 + PA_ROUNDS/UNROLL + 1 cycles; 14 with defaults.
- Each AD/DB block: PB_ROUNDS/UNROLL cycles, with xor on the first.
- Final block to valid_tag: PA_ROUNDS/UNROLL cycles, then TAG for 1 cycle.
- rst_n low mid-operation: immediate return to reset values.

## Test plan
- Defaults, 1 AD block (last_ad), 1 DB (last_db), encrypt → valid_tag 14+1+8+1+12 = 36 cycles after start; rnd_idx sequences 0..11, 4..11, 0..11; sel_xor_key 01 then 10; end_ad pulse once.
- Empty AD, empty DB: valid_db_in+last_db in first WAIT_AD → FINAL with sel_xor_key=11, end_ad=1, tag after 12 cycles.
- Decrypt, 2 DB blocks, tag_match=0 → sel_decrypt=1 on both xor cycles, auth_fail=1 with valid_tag; repeat with tag_match=1 → auth_fail=0.
- UNROLL=4 → init 3 cycles with rnd_idx 0,4,8; AD 2 cycles with rnd_idx 4,8; ready at cycle 5 after start.
- valid_ad and valid_db_in together in WAIT_AD → AD absorbed first; DB still pending and accepted next WAIT state.
- abort during ABS_DB and rst_n low during INIT → IDLE next cycle / immediately, no valid_tag; following start runs a clean operation.

Source files
------------

// File: rtl/ascon_aead_fsm_param.sv
`default_nettype none
// ============================================================================
// Module   : ascon_aead_fsm_param
// Purpose  : Parametrised control FSM for the Ascon-AEAD128 core. It
//            sequences initialisation, associated-data absorption, data
//            encryption/decryption, finalisation and tag output. Round
//            counts and rounds-per-cycle unrolling are parameters. The FSM
//            owns the permutation round counter.
// Ports    : clk, rst_n (async active-low)
//            start/decrypt/abort    - host command, mode and abort
//            valid_ad/last_ad       - associated-data block handshake
//            valid_db_in/last_db    - data block handshake
//            tag_match              - datapath tag comparator (TAG state)
//            rnd_idx/perm_en        - round-constant index / permute enable
//            en_internal/en_new_aead, sel_* , end_ad - datapath controls
//            ready, valid_db_out, valid_tag, auth_fail, busy - status
// Revision : 1.0 - initial release
// ============================================================================
module ascon_aead_fsm_param #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 8,
  parameter int UNROLL    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       decrypt,
  input  logic       abort,
  input  logic       valid_ad,
  input  logic       last_ad,
  input  logic       valid_db_in,
  input  logic       last_db,
  input  logic       tag_match,
  output logic [3:0] rnd_idx,
  output logic       perm_en,
  output logic       en_internal,
  output logic       en_new_aead,
  output logic       sel_state,
  output logic       sel_din,
  output logic       sel_dout,
  output logic       sel_xor_data,
  output logic [1:0] sel_xor_key,
  output logic       sel_decrypt,
  output logic       end_ad,
  output logic       ready,
  output logic       valid_db_out,
  output logic       valid_tag,
  output logic       auth_fail,
  output logic       busy
);

  localparam int         PA_GROUPS = PA_ROUNDS / UNROLL;
  localparam int         PB_GROUPS = PB_ROUNDS / UNROLL;
  localparam logic [3:0] PA_BASE   = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] PB_BASE   = 4'(12 - PB_ROUNDS);
  localparam logic [3:0] PA_LAST   = 4'(PA_GROUPS - 1);
  localparam logic [3:0] PB_LAST   = 4'(PB_GROUPS - 1);
  localparam logic [3:0] STEP      = 4'(UNROLL);

  // Reject round/unroll combinations the counter cannot sequence exactly.
  generate
    if (UNROLL < 1 || PA_ROUNDS < 1 || PA_ROUNDS > 12 ||
        PB_ROUNDS < 1 || PB_ROUNDS > 12 ||
        (PA_ROUNDS % UNROLL) != 0 || (PB_ROUNDS % UNROLL) != 0) begin : g_param_check
      $error("ascon_aead_fsm_param: UNROLL must divide PA_ROUNDS and PB_ROUNDS (1..12)");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_INIT    = 4'd2,
    S_WAIT_AD = 4'd3,
    S_ABS_AD  = 4'd4,
    S_WAIT_DB = 4'd5,
    S_ABS_DB  = 4'd6,
    S_FINAL   = 4'd7,
    S_TAG     = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] k_q, k_d;
  logic       mode_q, mode_d;          // 1 = decrypt
  logic       absorbed_q, absorbed_d;  // any block absorbed since LOAD
  logic       dsep_q, dsep_d;          // domain separation already applied
  logic       last_ad_q, last_ad_d;    // current AD block is the final one

  logic first_grp;
  logic last_pa;
  logic last_pb;

  assign first_grp = (k_q == 4'd0);
  assign last_pa   = (k_q == PA_LAST);
  assign last_pb   = (k_q == PB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 4'd0;
      mode_q     <= 1'b0;
      absorbed_q <= 1'b0;
      dsep_q     <= 1'b0;
      last_ad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      absorbed_q <= absorbed_d;
      dsep_q     <= dsep_d;
      last_ad_q  <= last_ad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    mode_d       = mode_q;
    absorbed_d   = absorbed_q;
    dsep_d       = dsep_q;
    last_ad_d    = last_ad_q;
    rnd_idx      = PA_BASE + k_q * STEP;
    perm_en      = 1'b0;
    en_internal  = 1'b0;
    en_new_aead  = 1'b0;
    sel_state    = 1'b0;
    sel_din      = 1'b0;
    sel_dout     = 1'b0;
    sel_xor_data = 1'b0;
    sel_xor_key  = 2'b00;
    sel_decrypt  = 1'b0;
    end_ad       = 1'b0;
    ready        = 1'b0;
    valid_db_out = 1'b0;
    valid_tag    = 1'b0;
    auth_fail    = 1'b0;
    busy         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          mode_d     = decrypt;
          absorbed_d = 1'b0;
          dsep_d     = 1'b0;
          last_ad_d  = 1'b0;
        end
      end

      S_LOAD: begin
        en_new_aead = 1'b1;
        en_internal = 1'b1;
        sel_state   = 1'b1;
        state_d     = S_INIT;
      end

      S_INIT: begin
        perm_en     = 1'b1;
        en_internal = 1'b1;
        if (last_pa) state_d = S_WAIT_AD;
      end

      S_WAIT_AD: begin
        ready = 1'b1;
        // AD has priority so a simultaneous data request stays pending.
        if (valid_ad) begin
          last_ad_d = last_ad;
          state_d   = S_ABS_AD;
        end else if (valid_db_in) begin
          state_d = last_db ? S_FINAL : S_ABS_DB;
        end
      end

      S_ABS_AD: begin
        perm_en     = 1'b1;
        en_internal = 1'b1;
        rnd_idx     = PB_BASE + k_q * STEP;
        if (first_grp) begin
          sel_xor_data = 1'b1;
          sel_xor_key  = absorbed_q ? 2'b00 : 2'b01;
          absorbed_d   = 1'b1;
        end
        if (last_pb) begin
          if (last_ad_q) begin
            // Domain separation lands as the state moves to data phase.
            end_ad  = 1'b1;
            dsep_d  = 1'b1;
            state_d = S_WAIT_DB;
          end else begin
            state_d = S_WAIT_AD;
          end
        end
      end

      S_WAIT_DB: begin
        ready = 1'b1;
        if (valid_db_in) state_d = last_db ? S_FINAL : S_ABS_DB;
      end

      S_ABS_DB: begin
        perm_en     = 1'b1;
        en_internal = 1'b1;
        rnd_idx     = PB_BASE + k_q * STEP;
        if (first_grp) begin
          sel_din      = 1'b1;
          sel_xor_data = 1'b1;
          valid_db_out = 1'b1;
          sel_decrypt  = mode_q;
          // Entering data without a final AD block: this xor carries the
          // initial key mix (if first absorption) and domain separation.
          sel_xor_key  = absorbed_q ? 2'b00 : 2'b01;
          end_ad       = ~dsep_q;
          absorbed_d   = 1'b1;
          dsep_d       = 1'b1;
        end
        if (last_pb) state_d = S_WAIT_DB;
      end

      S_FINAL: begin
        perm_en     = 1'b1;
        en_internal = 1'b1;
        if (first_grp) begin
          sel_din      = 1'b1;
          sel_xor_data = 1'b1;
          valid_db_out = 1'b1;
          sel_decrypt  = mode_q;
          // K||K folds the skipped initial 0||K mix into the final key xor.
          sel_xor_key  = absorbed_q ? 2'b10 : 2'b11;
          end_ad       = ~dsep_q;
          absorbed_d   = 1'b1;
          dsep_d       = 1'b1;
        end
        if (last_pa) state_d = S_TAG;
      end

      S_TAG: begin
        sel_xor_key = 2'b01;
        sel_dout    = 1'b1;
        valid_tag   = 1'b1;
        auth_fail   = mode_q & ~tag_match;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Group counter restarts on every state change, advances while permuting.
    if (state_d != state_q) begin
      k_d = 4'd0;
    end else if (perm_en) begin
      k_d = k_q + 4'd1;
    end

    if (abort) begin
      state_d    = S_IDLE;
      k_d        = 4'd0;
      absorbed_d = 1'b0;
      dsep_d     = 1'b0;
      last_ad_d  = 1'b0;
    end
  end

endmodule
`default_nettype wire
